// File: rtl/vc_input_buffer_if.sv
// Flit type shared by the NoC, and the bundle of signals between the link
// receiver side and the per-port VC input buffer.
package params_noc;
    typedef struct packed {
        logic [1:0]  flit_type;
        logic [3:0]  x_Dest;
        logic [3:0]  y_Dest;
        logic [21:0] payload;
    } flit_Data_noVC;
endpackage

interface vc_input_buffer_if #(
    parameter int VC_NUM      = 2,
    parameter int BUFFER_SIZE = 8
);
    import params_noc::*;

    localparam int VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int CW  = $clog2(BUFFER_SIZE) + 1;

    logic                 write_i;
    logic [VCW-1:0]       write_vc_i;
    flit_Data_noVC        data_i;
    logic                 read_i;
    logic [VCW-1:0]       read_vc_i;
    flit_Data_noVC        data_o;
    logic [VC_NUM-1:0]    empty_o;
    logic [VC_NUM-1:0]    full_o;
    logic [VC_NUM-1:0]    on_off_o;
    logic [VC_NUM*CW-1:0] count_o;
    logic                 wr_err_o;
    logic                 rd_err_o;

    modport master (
        output write_i, write_vc_i, data_i, read_i, read_vc_i,
        input  data_o, empty_o, full_o, on_off_o, count_o, wr_err_o, rd_err_o
    );

    modport slave (
        input  write_i, write_vc_i, data_i, read_i, read_vc_i,
        output data_o, empty_o, full_o, on_off_o, count_o, wr_err_o, rd_err_o
    );
endinterface

// File: rtl/vc_input_buffer.sv
// Per-port NoC input buffer: VC_NUM circular flit FIFOs with first-word
// fall-through read, per-VC occupancy, error pulses and hysteretic on/off.
module vc_input_buffer
    import params_noc::*;
#(
    parameter int VC_NUM      = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int OFF_THRESH  = 6,
    parameter int ON_THRESH   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    vc_input_buffer_if.slave bus
);
    localparam int VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int PW  = $clog2(BUFFER_SIZE);
    localparam int CW  = PW + 1;
    localparam logic [VCW:0]  VC_LIMIT = (VCW + 1)'(VC_NUM);
    localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_SIZE);
    localparam logic [CW-1:0] OFF_CNT  = CW'(OFF_THRESH);
    localparam logic [CW-1:0] ON_CNT   = CW'(ON_THRESH);

    flit_Data_noVC     mem_r       [VC_NUM][BUFFER_SIZE];
    logic [PW-1:0]     wr_ptr_r    [VC_NUM];
    logic [PW-1:0]     rd_ptr_r    [VC_NUM];
    logic [CW-1:0]     count_r     [VC_NUM];
    logic [CW-1:0]     count_nxt_s [VC_NUM];
    logic [VC_NUM-1:0] on_off_r;
    logic [VC_NUM-1:0] on_off_nxt_s;
    logic [VC_NUM-1:0] wr_en_s;
    logic [VC_NUM-1:0] rd_en_s;
    logic [VC_NUM-1:0] empty_s;
    logic [VC_NUM-1:0] full_s;
    logic              wr_vc_ok_s;
    logic              rd_vc_ok_s;
    logic              wr_err_nxt_s;
    logic              rd_err_nxt_s;
    logic              wr_err_r;
    logic              rd_err_r;
    flit_Data_noVC     data_s;

    assign wr_vc_ok_s = ({1'b0, bus.write_vc_i} < VC_LIMIT);
    assign rd_vc_ok_s = ({1'b0, bus.read_vc_i} < VC_LIMIT);

    // Flags from registered occupancy, plus legality of this cycle's operations.
    always_comb begin
        empty_s      = '0;
        full_s       = '0;
        wr_en_s      = '0;
        rd_en_s      = '0;
        wr_err_nxt_s = 1'b0;
        rd_err_nxt_s = 1'b0;
        for (int v = 0; v < VC_NUM; v++) begin
            empty_s[v] = (count_r[v] == '0);
            full_s[v]  = (count_r[v] == FULL_CNT);
            wr_en_s[v] = bus.write_i && wr_vc_ok_s && (bus.write_vc_i == VCW'(v)) && !full_s[v];
            rd_en_s[v] = bus.read_i && rd_vc_ok_s && (bus.read_vc_i == VCW'(v)) && !empty_s[v];
            // Errors only for in-range VCs; out-of-range requests are silent no-ops.
            if (bus.write_i && wr_vc_ok_s && (bus.write_vc_i == VCW'(v)) && full_s[v]) begin
                wr_err_nxt_s = 1'b1;
            end else begin
                wr_err_nxt_s = wr_err_nxt_s;
            end
            if (bus.read_i && rd_vc_ok_s && (bus.read_vc_i == VCW'(v)) && empty_s[v]) begin
                rd_err_nxt_s = 1'b1;
            end else begin
                rd_err_nxt_s = rd_err_nxt_s;
            end
        end
    end

    // Next occupancy and hysteretic flow-control decision per VC.
    always_comb begin
        on_off_nxt_s = on_off_r;
        for (int v = 0; v < VC_NUM; v++) begin
            case ({wr_en_s[v], rd_en_s[v]})
                2'b10:   count_nxt_s[v] = count_r[v] + CW'(1);
                2'b01:   count_nxt_s[v] = count_r[v] - CW'(1);
                default: count_nxt_s[v] = count_r[v];
            endcase
            if (on_off_r[v] && (count_nxt_s[v] >= OFF_CNT)) begin
                on_off_nxt_s[v] = 1'b0;
            end else if (!on_off_r[v] && (count_nxt_s[v] <= ON_CNT)) begin
                on_off_nxt_s[v] = 1'b1;
            end else begin
                on_off_nxt_s[v] = on_off_r[v];
            end
        end
    end

    // Pointer, occupancy, flow-control and error-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VC_NUM; v++) begin
                wr_ptr_r[v] <= '0;
                rd_ptr_r[v] <= '0;
                count_r[v]  <= '0;
            end
            on_off_r <= '1;
            wr_err_r <= 1'b0;
            rd_err_r <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (wr_en_s[v]) wr_ptr_r[v] <= wr_ptr_r[v] + PW'(1);
                if (rd_en_s[v]) rd_ptr_r[v] <= rd_ptr_r[v] + PW'(1);
                count_r[v] <= count_nxt_s[v];
            end
            on_off_r <= on_off_nxt_s;
            wr_err_r <= wr_err_nxt_s;
            rd_err_r <= rd_err_nxt_s;
        end
    end

    // Flit storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (wr_en_s[v]) mem_r[v][wr_ptr_r[v]] <= bus.data_i;
        end
    end

    // Fall-through head of the selected VC.
    always_comb begin
        data_s = '0;
        if (rd_vc_ok_s) begin
            data_s = mem_r[bus.read_vc_i][rd_ptr_r[bus.read_vc_i]];
        end else begin
            data_s = '0;
        end
    end

    // Pack per-VC occupancy onto the shared count bus.
    always_comb begin
        bus.count_o = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            bus.count_o[v*CW +: CW] = count_r[v];
        end
    end

    assign bus.data_o   = data_s;
    assign bus.empty_o  = empty_s;
    assign bus.full_o   = full_s;
    assign bus.on_off_o = on_off_r;
    assign bus.wr_err_o = wr_err_r;
    assign bus.rd_err_o = rd_err_r;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Self-checking bench for vc_input_buffer: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_vc_input_buffer;
    import params_noc::*;

    localparam int VC_NUM = 2;
    localparam int BS     = 8;
    localparam int OFF    = 6;
    localparam int ON     = 2;
    localparam int CW     = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vc_input_buffer_if #(.VC_NUM(VC_NUM), .BUFFER_SIZE(BS)) bus ();

    vc_input_buffer #(
        .VC_NUM(VC_NUM), .BUFFER_SIZE(BS), .OFF_THRESH(OFF), .ON_THRESH(ON)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    flit_Data_noVC mq [VC_NUM][$];
    bit exp_on [VC_NUM];
    bit exp_wr_err;
    bit exp_rd_err;

    function automatic logic [VC_NUM*CW-1:0] exp_count();
        logic [VC_NUM*CW-1:0] r = '0;
        for (int v = 0; v < VC_NUM; v++) r[v*CW +: CW] = CW'(mq[v].size());
        return r;
    endfunction

    function automatic logic [VC_NUM-1:0] exp_empty();
        logic [VC_NUM-1:0] r = '0;
        for (int v = 0; v < VC_NUM; v++) r[v] = (mq[v].size() == 0);
        return r;
    endfunction

    function automatic logic [VC_NUM-1:0] exp_full();
        logic [VC_NUM-1:0] r = '0;
        for (int v = 0; v < VC_NUM; v++) r[v] = (mq[v].size() == BS);
        return r;
    endfunction

    function automatic logic [VC_NUM-1:0] exp_onoff();
        logic [VC_NUM-1:0] r = '0;
        for (int v = 0; v < VC_NUM; v++) r[v] = exp_on[v];
        return r;
    endfunction

    function automatic flit_Data_noVC rand_flit();
        return flit_Data_noVC'($urandom());
    endfunction

    function automatic int cnt_of(int v);
        logic [VC_NUM*CW-1:0] c = bus.count_o;
        return int'(c[v*CW +: CW]);
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VC_NUM; v++) begin
            mq[v].delete();
            exp_on[v] = 1'b1;
        end
        exp_wr_err = 1'b0;
        exp_rd_err = 1'b0;
    endtask

    // One clock of stimulus; returns the observed head and the model's head.
    task automatic step(input bit w, input int wvc, input flit_Data_noVC d,
                        input bit r, input int rvc,
                        output flit_Data_noVC seen, output flit_Data_noVC want,
                        output bit popped);
        bit wr_ok;
        bus.write_i    = w;
        bus.write_vc_i = 1'(wvc);
        bus.data_i     = d;
        bus.read_i     = r;
        bus.read_vc_i  = 1'(rvc);
        #1;
        seen       = bus.data_o;
        popped     = r && (mq[rvc].size() > 0);
        want       = popped ? mq[rvc][0] : '0;
        wr_ok      = w && (mq[wvc].size() < BS);
        exp_wr_err = w && (mq[wvc].size() == BS);
        exp_rd_err = r && (mq[rvc].size() == 0);
        @(posedge clk);
        #1;
        if (popped) void'(mq[rvc].pop_front());
        if (wr_ok) mq[wvc].push_back(d);
        for (int v = 0; v < VC_NUM; v++) begin
            if (exp_on[v] && mq[v].size() >= OFF) exp_on[v] = 1'b0;
            else if (!exp_on[v] && mq[v].size() <= ON) exp_on[v] = 1'b1;
        end
        bus.write_i = 1'b0;
        bus.read_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.write_i = 1'b0; bus.write_vc_i = '0; bus.data_i = '0;
        bus.read_i = 1'b0;  bus.read_vc_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.count_o !== '0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", bus.count_o); end
        n_cmp++; if (bus.empty_o !== 2'b11) begin n_fail++; $display("FAIL reset_empty: got %b expected 11", bus.empty_o); end
        n_cmp++; if (bus.full_o !== 2'b00) begin n_fail++; $display("FAIL reset_full: got %b expected 00", bus.full_o); end
        n_cmp++; if (bus.on_off_o !== 2'b11) begin n_fail++; $display("FAIL reset_onoff: got %b expected 11", bus.on_off_o); end
        n_cmp++; if ({bus.wr_err_o, bus.rd_err_o} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", {bus.wr_err_o, bus.rd_err_o}); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fifo_order();
        flit_Data_noVC f, seen, want;
        bit popped;
        for (int i = 1; i <= 3; i++) begin
            f = rand_flit();
            f.x_Dest = 4'(i);
            step(1'b1, 0, f, 1'b0, 0, seen, want, popped);
            n_cmp++; if (cnt_of(0) != i) begin n_fail++; $display("FAIL order_wr_count: got %0d expected %0d", cnt_of(0), i); end
        end
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 0, '0, 1'b1, 0, seen, want, popped);
            n_cmp++; if (seen.x_Dest !== 4'(i)) begin n_fail++; $display("FAIL order_head: got x_Dest %0d expected %0d", seen.x_Dest, i); end
            n_cmp++; if (seen !== want) begin n_fail++; $display("FAIL order_flit: got %h expected %h", seen, want); end
            n_cmp++; if (cnt_of(0) != 3 - i) begin n_fail++; $display("FAIL order_rd_count: got %0d expected %0d", cnt_of(0), 3 - i); end
        end
        n_cmp++; if (bus.empty_o !== 2'b11) begin n_fail++; $display("FAIL order_empty: got %b expected 11", bus.empty_o); end
        n_cmp++; if (cnt_of(1) != 0) begin n_fail++; $display("FAIL order_vc1: got %0d expected 0", cnt_of(1)); end
    endtask

    task automatic test_full();
        flit_Data_noVC seen, want;
        bit popped;
        for (int i = 0; i < BS; i++) step(1'b1, 1, rand_flit(), 1'b0, 0, seen, want, popped);
        n_cmp++; if (bus.full_o !== 2'b10) begin n_fail++; $display("FAIL full_flag: got %b expected 10", bus.full_o); end
        step(1'b1, 1, rand_flit(), 1'b0, 0, seen, want, popped);
        n_cmp++; if (bus.wr_err_o !== 1'b1) begin n_fail++; $display("FAIL full_wr_err: got %b expected 1", bus.wr_err_o); end
        n_cmp++; if (cnt_of(1) != BS) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", cnt_of(1), BS); end
        step(1'b0, 0, '0, 1'b0, 0, seen, want, popped);
        n_cmp++; if (bus.wr_err_o !== 1'b0) begin n_fail++; $display("FAIL full_err_pulse: got %b expected 0", bus.wr_err_o); end
        for (int i = 0; i < BS; i++) begin
            step(1'b0, 0, '0, 1'b1, 1, seen, want, popped);
            n_cmp++; if (seen !== want || !popped) begin n_fail++; $display("FAIL full_drain: got %h expected %h", seen, want); end
        end
        n_cmp++; if (bus.empty_o[1] !== 1'b1) begin n_fail++; $display("FAIL full_empty: got %b expected 1", bus.empty_o[1]); end
    endtask

    task automatic test_wrap();
        flit_Data_noVC seen, want;
        bit popped;
        for (int i = 0; i <= 20; i++) begin
            step(i < 20, 0, rand_flit(), i > 0, 0, seen, want, popped);
            if (popped) begin
                n_cmp++; if (seen !== want) begin n_fail++; $display("FAIL wrap_head: got %h expected %h", seen, want); end
            end
            n_cmp++; if (cnt_of(0) > 2 || bus.count_o !== exp_count()) begin n_fail++; $display("FAIL wrap_count: got %h expected %h", bus.count_o, exp_count()); end
        end
    endtask

    task automatic test_flow_control();
        flit_Data_noVC seen, want;
        bit popped;
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 0, rand_flit(), 1'b0, 0, seen, want, popped);
            n_cmp++; if (bus.on_off_o[0] !== (i < 6)) begin n_fail++; $display("FAIL fc_up: got %b expected %b at count %0d", bus.on_off_o[0], i < 6, i); end
        end
        for (int c = 5; c >= 0; c--) begin
            step(1'b0, 0, '0, 1'b1, 0, seen, want, popped);
            n_cmp++; if (bus.on_off_o[0] !== (c <= 2)) begin n_fail++; $display("FAIL fc_down: got %b expected %b at count %0d", bus.on_off_o[0], c <= 2, c); end
            n_cmp++; if (seen !== want) begin n_fail++; $display("FAIL fc_head: got %h expected %h", seen, want); end
        end
    endtask

    task automatic test_simultaneous();
        flit_Data_noVC seen, want, d0;
        bit popped;
        d0 = rand_flit();
        step(1'b1, 0, d0, 1'b1, 0, seen, want, popped);
        n_cmp++; if ({bus.rd_err_o, bus.wr_err_o} !== 2'b10) begin n_fail++; $display("FAIL sim_empty_err: got rd/wr %b expected 10", {bus.rd_err_o, bus.wr_err_o}); end
        n_cmp++; if (cnt_of(0) != 1) begin n_fail++; $display("FAIL sim_empty_count: got %0d expected 1", cnt_of(0)); end
        for (int i = 0; i < BS; i++) step(1'b1, 1, rand_flit(), 1'b0, 0, seen, want, popped);
        step(1'b1, 1, rand_flit(), 1'b1, 1, seen, want, popped);
        n_cmp++; if ({bus.rd_err_o, bus.wr_err_o} !== 2'b01) begin n_fail++; $display("FAIL sim_full_err: got rd/wr %b expected 01", {bus.rd_err_o, bus.wr_err_o}); end
        n_cmp++; if (cnt_of(1) != BS - 1) begin n_fail++; $display("FAIL sim_full_count: got %0d expected %0d", cnt_of(1), BS - 1); end
        n_cmp++; if (seen !== want) begin n_fail++; $display("FAIL sim_full_head: got %h expected %h", seen, want); end
        step(1'b1, 1, rand_flit(), 1'b1, 0, seen, want, popped);
        n_cmp++; if (seen !== d0) begin n_fail++; $display("FAIL sim_cross_head: got %h expected %h", seen, d0); end
        n_cmp++; if (cnt_of(0) != 0 || cnt_of(1) != BS) begin n_fail++; $display("FAIL sim_cross_count: got %h expected %h", bus.count_o, {4'(BS), 4'd0}); end
        n_cmp++; if ({bus.rd_err_o, bus.wr_err_o} !== 2'b00) begin n_fail++; $display("FAIL sim_cross_err: got %b expected 00", {bus.rd_err_o, bus.wr_err_o}); end
    endtask

    task automatic test_async_reset();
        flit_Data_noVC seen, want;
        bit popped;
        for (int i = 0; i < 5; i++) step(1'b1, 0, rand_flit(), 1'b0, 0, seen, want, popped);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (bus.count_o !== '0) begin n_fail++; $display("FAIL arst_count: got %h expected 0", bus.count_o); end
        n_cmp++; if (bus.empty_o !== 2'b11) begin n_fail++; $display("FAIL arst_empty: got %b expected 11", bus.empty_o); end
        n_cmp++; if (bus.on_off_o !== 2'b11) begin n_fail++; $display("FAIL arst_onoff: got %b expected 11", bus.on_off_o); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(i < 2, 1, rand_flit(), i >= 2, 1, seen, want, popped);
            if (popped) begin
                n_cmp++; if (seen !== want) begin n_fail++; $display("FAIL arst_after: got %h expected %h", seen, want); end
            end
        end
        n_cmp++; if (bus.count_o !== exp_count()) begin n_fail++; $display("FAIL arst_final: got %h expected %h", bus.count_o, exp_count()); end
    endtask

    task automatic test_random();
        flit_Data_noVC seen, want;
        bit popped;
        bit w, r;
        int wvc, rvc;
        for (int i = 0; i < 600; i++) begin
            // Bias toward writes in the first half so the VCs reach full/off.
            w   = ($urandom_range(99) < ((i < 300) ? 70 : 40));
            r   = ($urandom_range(99) < ((i < 300) ? 35 : 60));
            wvc = int'($urandom_range(VC_NUM - 1));
            rvc = int'($urandom_range(VC_NUM - 1));
            step(w, wvc, rand_flit(), r, rvc, seen, want, popped);
            if (popped) begin
                n_cmp++; if (seen !== want) begin n_fail++; $display("FAIL rnd_head[%0d]: got %h expected %h", i, seen, want); end
            end
            n_cmp++; if (bus.count_o !== exp_count()) begin n_fail++; $display("FAIL rnd_count[%0d]: got %h expected %h", i, bus.count_o, exp_count()); end
            n_cmp++; if (bus.empty_o !== exp_empty() || bus.full_o !== exp_full()) begin n_fail++; $display("FAIL rnd_flags[%0d]: got e%b f%b expected e%b f%b", i, bus.empty_o, bus.full_o, exp_empty(), exp_full()); end
            n_cmp++; if (bus.on_off_o !== exp_onoff()) begin n_fail++; $display("FAIL rnd_onoff[%0d]: got %b expected %b", i, bus.on_off_o, exp_onoff()); end
            n_cmp++; if (bus.wr_err_o !== exp_wr_err || bus.rd_err_o !== exp_rd_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got wr%b rd%b expected wr%b rd%b", i, bus.wr_err_o, bus.rd_err_o, exp_wr_err, exp_rd_err); end
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_full();
        test_wrap();
        test_flow_control();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
